billing_ctrl: RTL
=================

# billing_ctrl

Parametrised billing controller for the washing-machine front panel. It quotes the price of the selected wash mode against the card balance and charges on confirmation. An idle penalty is deducted per period while the customer does not confirm, and the controller locks when the resulting debt reaches a limit. Sits between the button debouncers / price-setting block and the `scan4` display drivers, and hands off to the wash sequencer via `next`.

## Interface
- `DIGITS`, 3: BCD digits of every money value; magnitude width W = 4*DIGITS.
- `MODES`, 4: number of wash modes in the price table; MW = max(1,$clog2(MODES)).
- `TICKS_PER_SEC`, 100_000_000: clk cycles per second tick.
- `PAY_TIMEOUT_S`, 8: seconds in QUOTE before penalties start.
- `FINE_PERIOD_S`, 1: seconds between penalty deductions.
- `DONE_TIMEOUT_S`, 8: seconds in DONE before automatic return.
- `MAX_DEBT`, 100 (as BCD 0x100): debt magnitude that forces LOCK.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `on`  in  1  machine powered; low freezes all state and counters.
- `bal`  in  W  card balance, BCD, non-negative.
- `mode`  in  MW  selected mode index.
- `price_tbl`  in  MODES*W  BCD prices; mode i at [i*W +: W].
- `fine`  in  W  BCD penalty per period.
- `confirm`  in  1  debounced single-cycle pulse.
- `cancel`  in  1  debounced single-cycle pulse.
- `any_key`  in  1  OR of all debounced key pulses.
- `state_o`  out  3  current state encoding.
- `bal_out`  out  W  working balance magnitude, BCD.
- `neg`  out  1  working balance sign (1 = debt).
- `disp_val`  out  W  value for the right display.
- `disp_is_price`  out  1  `disp_val` shows price, not balance.
- `countdown`  out  8  seconds remaining in QUOTE or DONE.
- `next`  out  1  one-cycle pulse: wash cycle finished, ready for the next customer.
- `buzz_en`  out  1  buzzer request.
- `lock`  out  1  debt limit reached.

## Operation
- States: QUOTE=0, PENALTY=1, PAID=2, DONE=3, LOCK=4. Reset enters QUOTE.
- Reset values: `bal_out`=0, `neg`=0, `disp_val`=0, `disp_is_price`=0, `countdown`=PAY_TIMEOUT_S, `next`=0, `buzz_en`=0, `lock`=0.
- QUOTE:
  - Working balance = `bal` (positive). Price follows `mode` continuously.
  - Display alternates balance and price on each tick; balance is shown first.
  - `buzz_en`=1. `countdown` decrements per tick.
  - On `confirm`: charge working−price into `bal_out`/`neg`, go to PAID.
  - When `countdown` reaches 0: go to PENALTY.
- PENALTY:
  - Every FINE_PERIOD_S, working balance −= `fine` (signed-magnitude BCD). Display shows the working balance.
  - If the balance is negative and its magnitude ≥ MAX_DEBT, go to LOCK.
  - On `confirm`: charge the penalised balance minus price, go to PAID.
- PAID:
  - Price is frozen and the result is displayed; `buzz_en`=0.
  - On `confirm`: go to DONE with `countdown`=DONE_TIMEOUT_S.
  - On `cancel`: refund. Working balance reverts to the pre-charge value, already-applied fines stand. Go to QUOTE with `countdown` reloaded.
- DONE:
  - `countdown` decrements per tick. `disp_val` walks digit 8 one position per tick.
  - On `countdown`=0 or `any_key`: pulse `next`, go to QUOTE.
- LOCK:
  - `lock`=1 and `buzz_en`=1. The display shows the debt.
  - Only `rst` exits this state.
- Arithmetic:
  - BCD signed-magnitude; zero is always positive.
  - A result magnitude above 10^DIGITS−1 saturates to all-9s and goes to LOCK.

## Timing
- Tick counter runs 0..TICKS_PER_SEC−1 and ticks when it wraps. It clears on every state entry, so the first tick comes TICKS_PER_SEC cycles after entry.
- The charge result is registered in the same cycle as the `confirm` edge. `bal_out` is valid in the first PAID cycle.
- `next` is high for exactly one cycle, in the cycle of the DONE→QUOTE transition.
- Simultaneous events:
  - `confirm` on the timeout tick: `confirm` wins and no penalty is applied.
  - `confirm` with a penalty tick in PENALTY: the fine is applied first, then the charge.
  - `confirm` with `cancel`: `cancel` wins in PAID; elsewhere `confirm` wins.
- `on` low holds every register, including the tick counter; outputs keep their values.
- Asynchronous reset mid-operation returns immediately to reset values. An in-flight charge is discarded.
- Non-BCD inputs: behaviour unspecified.

## Structure
- Package `billing_pkg`: state enum and the BCD digit constants BLANK=4'd11 and SIGN=4'd10, shared with the display drivers.
- Sub-module `bcd_signed_sub`, purely combinational:
  - Inputs: sign plus W-bit magnitude, and a W-bit subtrahend.
  - Outputs: sign, magnitude and an overflow flag.
  - Digit loop with borrow and ten's-complement correction.

## Test plan
Bench parameters: DIGITS=3, TICKS_PER_SEC=4, PAY_TIMEOUT_S=8.
- `bal`=0x196, mode 1 price 0x045, `confirm` at cycle 10 → PAID next cycle, `bal_out`=0x151, `neg`=0; then `confirm` → DONE.
- No `confirm`, `fine`=0x028, `bal`=0x020:
  - After 32 cycles in QUOTE, enter PENALTY.
  - First fine at +4 cycles gives `neg`=1, `bal_out`=0x008.
  - After the next four fines the debt is 0x120, above MAX_DEBT 0x100 → LOCK with `lock`=1.
- In PAID after charging 0x045 from 0x196, `cancel` → QUOTE with `bal_out`=0x196 and `countdown`=8.
- DONE with no keys → `next` pulses exactly once after 32 cycles. A second run with `any_key` at cycle 3 → `next` pulses at cycle 3.
- `confirm` on the same cycle as the QUOTE timeout → PAID, no fine applied. `on` low for 20 cycles in QUOTE → `countdown` unchanged.
- `rst` low for 1 cycle while in PENALTY with debt → all outputs at reset values, `state_o`=QUOTE.

Source files
------------

// File: rtl/billing_pkg.sv
// rtl/billing_pkg.sv - billing controller state encoding and display digit codes
package billing_pkg;

  typedef enum logic [2:0] {
    ST_QUOTE   = 3'd0,
    ST_PENALTY = 3'd1,
    ST_PAID    = 3'd2,
    ST_DONE    = 3'd3,
    ST_LOCK    = 3'd4
  } billing_state_e;

  // Non-numeric digit codes understood by the scan4 display drivers
  localparam logic [3:0] BLANK = 4'd11;
  localparam logic [3:0] SIGN  = 4'd10;

endpackage

// File: rtl/bcd_signed_sub.sv
// rtl/bcd_signed_sub.sv - signed-magnitude BCD subtract (a - b), saturating on overflow
module bcd_signed_sub #(
  parameter int DIGITS = 3
) (
  input  logic                  a_neg,
  input  logic [4*DIGITS-1:0]   a_mag,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  y_neg,
  output logic [4*DIGITS-1:0]   y_mag,
  output logic                  ovf
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

  logic [W-1:0] sum, diff, cmp;
  logic         carry, borrow, c2;
  logic [4:0]   t;

  always_comb begin
    sum    = '0;
    diff   = '0;
    cmp    = '0;
    carry  = 1'b0;
    borrow = 1'b0;
    c2     = 1'b1;
    t      = '0;
    // Debt minus a positive amount grows the magnitude
    for (int i = 0; i < DIGITS; i++) begin
      t = {1'b0, a_mag[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, carry};
      if (t > 5'd9) begin
        t     = t - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = t[3:0];
    end
    for (int i = 0; i < DIGITS; i++) begin
      t = {1'b0, a_mag[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'd0, borrow};
      if (t[4]) begin
        t      = t + 5'd10;
        borrow = 1'b1;
      end else begin
        borrow = 1'b0;
      end
      diff[4*i +: 4] = t[3:0];
    end
    // Final borrow leaves a ten's complement; recover the magnitude
    for (int i = 0; i < DIGITS; i++) begin
      t = 5'd9 - {1'b0, diff[4*i +: 4]} + {4'd0, c2};
      if (t > 5'd9) begin
        t  = t - 5'd10;
        c2 = 1'b1;
      end else begin
        c2 = 1'b0;
      end
      cmp[4*i +: 4] = t[3:0];
    end

    ovf   = 1'b0;
    y_neg = 1'b0;
    y_mag = diff;
    if (a_neg) begin
      ovf   = carry;
      y_neg = 1'b1;
      y_mag = carry ? ALL9 : sum;
    end else if (borrow) begin
      y_neg = 1'b1;
      y_mag = cmp;
    end
    if (y_mag == '0) y_neg = 1'b0;
  end

endmodule

// File: rtl/billing_ctrl.sv
// rtl/billing_ctrl.sv - quotes the mode price against the card balance, charges, fines idling and locks on debt
module billing_ctrl
  import billing_pkg::*;
#(
  parameter int DIGITS         = 3,
  parameter int MODES          = 4,
  parameter int TICKS_PER_SEC  = 100_000_000,
  parameter int PAY_TIMEOUT_S  = 8,
  parameter int FINE_PERIOD_S  = 1,
  parameter int DONE_TIMEOUT_S = 8,
  parameter logic [4*DIGITS-1:0] MAX_DEBT = 'h100,
  localparam int W  = 4 * DIGITS,
  localparam int MW = (MODES > 1) ? $clog2(MODES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               on,
  input  logic [W-1:0]       bal,
  input  logic [MW-1:0]      mode,
  input  logic [MODES*W-1:0] price_tbl,
  input  logic [W-1:0]       fine,
  input  logic               confirm,
  input  logic               cancel,
  input  logic               any_key,
  output logic [2:0]         state_o,
  output logic [W-1:0]       bal_out,
  output logic               neg,
  output logic [W-1:0]       disp_val,
  output logic               disp_is_price,
  output logic [7:0]         countdown,
  output logic               next,
  output logic               buzz_en,
  output logic               lock
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    PAY_CD    = 8'(PAY_TIMEOUT_S);
  localparam logic [7:0]    DONE_CD   = 8'(DONE_TIMEOUT_S);
  localparam logic [7:0]    FINE_LAST = 8'(FINE_PERIOD_S - 1);
  localparam logic [PW-1:0] WALK_LAST = PW'(DIGITS - 1);

  billing_state_e state, state_n;
  logic [TW-1:0]  tick_cnt, tick_n;
  logic [7:0]     cd_n, fine_sec, fine_sec_n;
  logic [W-1:0]   work_mag_n, pre_mag, pre_mag_n, disp_n;
  logic           work_neg_n, pre_neg, pre_neg_n;
  logic           penalised, penalised_n, show_price, show_n;
  logic [PW-1:0]  walk, walk_n;
  logic           is_price_n, buzz_n, lock_n;
  logic           tick, fine_now;

  logic [W-1:0]   price_cur, src_mag, fine_mag, chg_a_mag, chg_mag;
  logic           src_neg, fine_neg, fine_ovf, chg_a_neg, chg_neg, chg_ovf;

  assign state_o   = state;
  assign price_cur = price_tbl[int'(mode)*W +: W];
  assign tick      = on && (tick_cnt == TICK_MAX);
  assign fine_now  = (state == ST_PENALTY) && tick && (fine_sec == FINE_LAST);
  // Until a fine has been applied, QUOTE works directly from the card balance
  assign src_mag   = (state == ST_QUOTE && !penalised) ? bal : bal_out;
  assign src_neg   = (state == ST_QUOTE && !penalised) ? 1'b0 : neg;
  assign chg_a_mag = fine_now ? fine_mag : src_mag;
  assign chg_a_neg = fine_now ? fine_neg : src_neg;

  bcd_signed_sub #(.DIGITS(DIGITS)) u_fine_sub (
    .a_neg(src_neg), .a_mag(src_mag), .b(fine),
    .y_neg(fine_neg), .y_mag(fine_mag), .ovf(fine_ovf)
  );

  bcd_signed_sub #(.DIGITS(DIGITS)) u_charge_sub (
    .a_neg(chg_a_neg), .a_mag(chg_a_mag), .b(price_cur),
    .y_neg(chg_neg), .y_mag(chg_mag), .ovf(chg_ovf)
  );

  always_comb begin
    state_n     = state;
    tick_n      = tick ? '0 : tick_cnt + 1'b1;
    cd_n        = countdown;
    fine_sec_n  = fine_sec;
    work_mag_n  = bal_out;
    work_neg_n  = neg;
    pre_mag_n   = pre_mag;
    pre_neg_n   = pre_neg;
    penalised_n = penalised;
    show_n      = show_price;
    walk_n      = walk;
    next        = 1'b0;
    if (on) begin
      case (state)
        ST_QUOTE: begin
          work_mag_n = src_mag;
          work_neg_n = src_neg;
          if (tick) begin
            show_n = ~show_price;
            cd_n   = countdown - 8'd1;
          end
          if (confirm) begin
            pre_mag_n  = src_mag;
            pre_neg_n  = src_neg;
            work_mag_n = chg_mag;
            work_neg_n = chg_neg;
            state_n    = chg_ovf ? ST_LOCK : ST_PAID;
          end else if (tick && countdown <= 8'd1) begin
            state_n = ST_PENALTY;
          end
        end
        ST_PENALTY: begin
          if (tick) fine_sec_n = fine_now ? 8'd0 : fine_sec + 8'd1;
          if (fine_now) begin
            work_mag_n  = fine_mag;
            work_neg_n  = fine_neg;
            penalised_n = 1'b1;
          end
          // Fine lands first, so the refund point already includes it
          if (confirm) begin
            pre_mag_n  = chg_a_mag;
            pre_neg_n  = chg_a_neg;
            work_mag_n = chg_mag;
            work_neg_n = chg_neg;
            state_n    = chg_ovf ? ST_LOCK : ST_PAID;
          end else if (fine_now && (fine_ovf || (fine_neg && fine_mag >= MAX_DEBT))) begin
            state_n = ST_LOCK;
          end
        end
        ST_PAID: begin
          if (cancel) begin
            work_mag_n = pre_mag;
            work_neg_n = pre_neg;
            state_n    = ST_QUOTE;
          end else if (confirm) begin
            state_n = ST_DONE;
          end
        end
        ST_DONE: begin
          if (tick) begin
            cd_n   = countdown - 8'd1;
            walk_n = (walk == WALK_LAST) ? '0 : walk + 1'b1;
          end
          if (any_key || (tick && countdown <= 8'd1)) begin
            next        = 1'b1;
            penalised_n = 1'b0;
            state_n     = ST_QUOTE;
          end
        end
        ST_LOCK: ;
        default: state_n = ST_QUOTE;
      endcase
      if (state_n != state) begin
        tick_n     = '0;
        fine_sec_n = '0;
        show_n     = 1'b0;
        walk_n     = '0;
        if (state_n == ST_QUOTE)     cd_n = PAY_CD;
        else if (state_n == ST_DONE) cd_n = DONE_CD;
      end
    end
  end

  // Display/buzzer/lock are registered from the next-state view so reset zeros them
  always_comb begin
    disp_n     = work_mag_n;
    is_price_n = 1'b0;
    buzz_n     = 1'b0;
    lock_n     = 1'b0;
    case (state_n)
      ST_QUOTE: begin
        buzz_n = 1'b1;
        if (show_n) begin
          disp_n     = price_cur;
          is_price_n = 1'b1;
        end
      end
      ST_PENALTY: buzz_n = 1'b1;
      ST_DONE: begin
        for (int i = 0; i < DIGITS; i++)
          disp_n[4*i +: 4] = (PW'(i) == walk_n) ? 4'h8 : BLANK;
      end
      ST_LOCK: begin
        buzz_n = 1'b1;
        lock_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_QUOTE;
      tick_cnt      <= '0;
      countdown     <= PAY_CD;
      fine_sec      <= '0;
      bal_out       <= '0;
      neg           <= 1'b0;
      pre_mag       <= '0;
      pre_neg       <= 1'b0;
      penalised     <= 1'b0;
      show_price    <= 1'b0;
      walk          <= '0;
      disp_val      <= '0;
      disp_is_price <= 1'b0;
      buzz_en       <= 1'b0;
      lock          <= 1'b0;
    end else if (on) begin
      state         <= state_n;
      tick_cnt      <= tick_n;
      countdown     <= cd_n;
      fine_sec      <= fine_sec_n;
      bal_out       <= work_mag_n;
      neg           <= work_neg_n;
      pre_mag       <= pre_mag_n;
      pre_neg       <= pre_neg_n;
      penalised     <= penalised_n;
      show_price    <= show_n;
      walk          <= walk_n;
      disp_val      <= disp_n;
      disp_is_price <= is_price_n;
      buzz_en       <= buzz_n;
      lock          <= lock_n;
    end
  end

endmodule
